// File: rtl/cache_pkg.sv
// Types and widths shared by the cache controller and its memory-side line-transfer engine.
package cache_pkg;
  localparam int LINE_ADDR_W = 18;
  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } cmi_state_t;
endpackage

// File: rtl/cache_mem_watchdog.sv
// Ack-wait watchdog: counts consecutive stalled request cycles and flags the LIMIT-th one.
module cache_mem_watchdog #(
  parameter int  LIMIT = 255,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stall,
  input  logic i_clr,
  output logic o_timeout
);
  logic [CW-1:0] r_cnt;

  // Fires during the LIMIT-th consecutive stalled cycle so the state moves on at its end.
  assign o_timeout = i_stall && (r_cnt == CW'(LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_stall) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cache_mem_if.sv
// Line-transfer engine: optional dirty write-back burst, then line-fill burst, then mem_ready pulse.
// Optional ack-wait watchdog (mem_err) is built only when CMI_TIMEOUT_EN is defined.
module cache_mem_if
  import cache_pkg::*;
#(
  parameter int  BEATS = 16
`ifdef CMI_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
  , localparam int BW = $clog2(BEATS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_evict,
  input  logic                   i_write_back,
  input  logic                   i_allocate,
  input  logic [LINE_ADDR_W-1:0] i_victim_line,
  input  logic [LINE_ADDR_W-1:0] i_fill_line,
  output logic [BW-1:0]          o_cache_rd_beat,
  input  logic [WORD_W-1:0]      i_cache_rdata,
  output logic                   o_fill_we,
  output logic [BW-1:0]          o_fill_beat,
  output logic [WORD_W-1:0]      o_fill_data,
  output logic                   o_mem_req,
  output logic                   o_mem_we,
  output logic [ADDR_W-1:0]      o_mem_addr,
  output logic [WORD_W-1:0]      o_mem_wdata,
  input  logic                   i_mem_ack,
  input  logic [WORD_W-1:0]      i_mem_rdata,
  output logic                   o_mem_ready,
  output logic                   o_mem_err
);
  cmi_state_t             r_state, w_state_nxt;
  logic [BW-1:0]          r_beat, w_beat_nxt;
  logic                   r_wb_pend, w_wb_clr;
  logic [LINE_ADDR_W-1:0] r_victim;
  logic                   r_fill_we, r_err, w_err_set;
  logic [BW-1:0]          r_fill_beat;
  logic [WORD_W-1:0]      r_fill_data;
  logic                   w_req, w_last, w_timeout;
  logic [LINE_ADDR_W-1:0] w_line;

  assign w_req  = (r_state == ST_WB) || (r_state == ST_FILL);
  assign w_last = (r_beat == BW'(BEATS - 1));
  assign w_line = (r_state == ST_WB) ? r_victim : i_fill_line;

`ifdef CMI_TIMEOUT_EN
  cache_mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_stall   (w_req && !i_mem_ack),
    .i_clr     (w_state_nxt != r_state),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_wb_clr    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_allocate) begin
          w_state_nxt = r_wb_pend ? ST_WB : ST_FILL;
          w_beat_nxt  = '0;
        end
      end
      ST_WB, ST_FILL: begin
        if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_wb_clr    = 1'b1;
          w_err_set   = 1'b1;
        end else if (i_mem_ack) begin
          w_beat_nxt = r_beat + BW'(1);
          if (w_last) begin
            w_state_nxt = (r_state == ST_WB) ? ST_FILL : ST_DONE;
            w_wb_clr    = (r_state == ST_WB);
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_wb_pend   <= 1'b0;
      r_victim    <= '0;
      r_fill_we   <= 1'b0;
      r_fill_beat <= '0;
      r_fill_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_beat    <= w_beat_nxt;
      r_err     <= w_err_set;
      r_fill_we <= (r_state == ST_FILL) && i_mem_ack;
      if ((r_state == ST_FILL) && i_mem_ack) begin
        r_fill_beat <= r_beat;
        r_fill_data <= i_mem_rdata;
      end
      // Evict is only meaningful between transfers; mid-burst pulses are dropped.
      if ((r_state == ST_IDLE) && i_evict) begin
        r_wb_pend <= i_write_back;
        r_victim  <= i_victim_line;
      end else if (w_wb_clr) begin
        r_wb_pend <= 1'b0;
      end
    end
  end

  assign o_cache_rd_beat = r_beat;
  assign o_mem_req       = w_req;
  assign o_mem_we        = (r_state == ST_WB);
  assign o_mem_addr      = w_req ? ({w_line, {(ADDR_W-LINE_ADDR_W){1'b0}}}
                                    | {{(ADDR_W-BW-2){1'b0}}, r_beat, 2'b00}) : '0;
  assign o_mem_wdata     = (r_state == ST_WB) ? i_cache_rdata : '0;
  assign o_fill_we       = r_fill_we;
  assign o_fill_beat     = r_fill_beat;
  assign o_fill_data     = r_fill_data;
  assign o_mem_ready     = (r_state == ST_DONE);
  assign o_mem_err       = r_err;
endmodule

// File: tb/tb_cache_mem_if.sv
// Directed bench for cache_mem_if with a request/fill scoreboard and a simple memory model.
`timescale 1ns/1ps
module tb_cache_mem_if;
  localparam int BEATS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evict = 1'b0, write_back = 1'b0, allocate = 1'b0;
  logic [17:0] victim_line = '0, fill_line = '0;
  logic [3:0]  rd_beat, fill_beat;
  logic [31:0] cache_rdata, fill_data, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        fill_we, mem_req, mem_we, mem_ready, mem_err;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_addr;

  int total = 0;
  int bad   = 0;

  typedef struct { logic we; logic [23:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [3:0] beat; logic [31:0] data; } fill_t;
  req_t  q_req[$];
  fill_t q_fill[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] cdat(input logic [3:0] b);
    return {16'hCA5E, 8'h00, 4'h9, b};
  endfunction

  function automatic logic [31:0] mdat(input logic [23:0] a);
    return {8'hD5, a};
  endfunction

  assign cache_rdata = cdat(rd_beat);

  cache_mem_if #(
    .BEATS(BEATS)
`ifdef CMI_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_evict(evict), .i_write_back(write_back),
    .i_allocate(allocate), .i_victim_line(victim_line), .i_fill_line(fill_line),
    .o_cache_rd_beat(rd_beat), .i_cache_rdata(cache_rdata),
    .o_fill_we(fill_we), .o_fill_beat(fill_beat), .o_fill_data(fill_data),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_mem_ready(mem_ready), .o_mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_evict(input logic wb, input logic [17:0] vline);
    evict = 1'b1; write_back = wb; victim_line = vline;
    @(posedge clk); #1;
    evict = 1'b0; write_back = 1'b0;
  endtask

  // Runs one allocate; acks every 'period' cycles; optional stray evict at cycle evict_at.
  task automatic run_xfer(input bit dirty, input logic [17:0] vline, input logic [17:0] fline,
                          input int period, input int evict_at);
    int    n       = dirty ? 2*BEATS : BEATS;
    int    exp_rdy = n*period + 1;
    bit    seen    = 1'b0;
    req_t  r;
    fill_t f;
    q_req.delete();
    q_fill.delete();
    if (dirty) begin
      for (int b = 0; b < BEATS; b++) begin
        r.we = 1'b1; r.addr = {vline, 4'(b), 2'b00}; r.wdata = cdat(4'(b));
        q_req.push_back(r);
      end
    end
    for (int b = 0; b < BEATS; b++) begin
      r.we = 1'b0; r.addr = {fline, 4'(b), 2'b00}; r.wdata = '0;
      q_req.push_back(r);
      f.beat = 4'(b); f.data = mdat(r.addr);
      q_fill.push_back(f);
    end
    fill_line = fline;
    allocate  = 1'b1;
    for (int cyc = 1; cyc <= exp_rdy + 20 && !seen; cyc++) begin
      @(posedge clk); #1;
      evict = (cyc == evict_at);
      write_back = (cyc == evict_at);
      if (cyc == evict_at) victim_line = 18'h3FFFF;
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (fill_we) begin
        if (q_fill.size() == 0) chk("spurious_fill_we", {63'd0, fill_we}, 64'd0);
        else begin
          f = q_fill.pop_front();
          chk("fill_beat", {60'd0, fill_beat}, {60'd0, f.beat});
          chk("fill_data", {32'd0, fill_data}, {32'd0, f.data});
        end
      end
      if (mem_req) begin
        if (q_req.size() == 0) chk("spurious_req", {63'd0, mem_req}, 64'd0);
        else begin
          r = q_req[0];
          chk("mem_we", {63'd0, mem_we}, {63'd0, r.we});
          chk("mem_addr", {40'd0, mem_addr}, {40'd0, r.addr});
          if (r.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, r.wdata});
          if (cyc % period == 0) begin
            mem_ack = 1'b1;
            mem_rdata = mdat(mem_addr);
            void'(q_req.pop_front());
          end
        end
      end
      if (mem_ready) begin
        seen = 1'b1;
        chk("ready_cycle", 64'(cyc), 64'(exp_rdy));
        chk("ready_err", {63'd0, mem_err}, 64'd0);
        allocate = 1'b0;
      end
    end
    evict = 1'b0; write_back = 1'b0; mem_ack = 1'b0; allocate = 1'b0;
    chk("ready_seen", {63'd0, seen}, 64'd1);
    chk("req_left", 64'(q_req.size()), 64'd0);
    chk("fill_left", 64'(q_fill.size()), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("idle_req", {63'd0, mem_req}, 64'd0);
      chk("idle_ready", {63'd0, mem_ready}, 64'd0);
    end
  endtask

  initial begin
    int rc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {63'd0, mem_req}, 64'd0);
    chk("rst_ready", {63'd0, mem_ready}, 64'd0);
    chk("rst_err", {63'd0, mem_err}, 64'd0);
    chk("rst_fill_we", {63'd0, fill_we}, 64'd0);
    chk("rst_addr", {40'd0, mem_addr}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_evict(1'b0, 18'h01234);
    run_xfer(1'b0, 18'h01234, 18'h000A5, 1, 0);

    do_evict(1'b1, 18'h3FFFF);
    run_xfer(1'b1, 18'h3FFFF, 18'h00155, 1, 0);

    do_evict(1'b1, 18'h0F0F0);
    run_xfer(1'b1, 18'h0F0F0, 18'h000C3, 3, 0);

    do_evict(1'b0, 18'h00000);
    run_xfer(1'b0, 18'h00000, 18'h00321, 1, 5);
    run_xfer(1'b0, 18'h00000, 18'h00322, 1, 0);

    // Reset in the middle of a fill burst.
    do_evict(1'b0, 18'h00000);
    fill_line = 18'h00123;
    allocate = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      mem_ack = mem_req;
      mem_rdata = mdat(mem_addr);
    end
    chk("pre_rst_addr", {40'd0, mem_addr}, {40'd0, 18'h00123, 4'd7, 2'b00});
    chk("pre_rst_fill_we", {63'd0, fill_we}, 64'd1);
    rst_n = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("midrst_req", {63'd0, mem_req}, 64'd0);
    chk("midrst_fill_we", {63'd0, fill_we}, 64'd0);
    chk("midrst_ready", {63'd0, mem_ready}, 64'd0);
    chk("midrst_addr", {40'd0, mem_addr}, 64'd0);
    allocate = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Dirty flag latched, then reset before allocate: must not survive.
    do_evict(1'b1, 18'h2AAAA);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_xfer(1'b0, 18'h00000, 18'h00456, 1, 0);

    // Ack never returns during fill.
    do_evict(1'b0, 18'h00000);
    fill_line = 18'h00077;
    allocate = 1'b1;
    mem_ack = 1'b0;
    rc = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (mem_ready && rc == 0) begin
        rc = cyc;
        chk("to_err", {63'd0, mem_err}, 64'd1);
        chk("to_fill_we", {63'd0, fill_we}, 64'd0);
        allocate = 1'b0;
      end
    end
`ifdef CMI_TIMEOUT_EN
    chk("to_cycle", 64'(rc), 64'd9);
    chk("to_after_err", {63'd0, mem_err}, 64'd0);
`else
    chk("stall_no_ready", 64'(rc), 64'd0);
    chk("stall_req", {63'd0, mem_req}, 64'd1);
    chk("stall_addr", {40'd0, mem_addr}, {40'd0, 18'h00077, 6'd0});
    chk("stall_err", {63'd0, mem_err}, 64'd0);
`endif
    allocate = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("final_rst_req", {63'd0, mem_req}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
